// File: rtl/zxunouart_fifo_pkg.sv
// Shared register map, status bit positions and engine states for the UART.
// Consumed by the UART top, its interface users and the testbench.
package zxunouart_fifo_pkg;

    localparam logic [7:0] UARTDATA = 8'hC6;
    localparam logic [7:0] UARTSTAT = 8'hC7;
    localparam logic [7:0] UARTBAUD = 8'hC8;

    localparam int ST_RX_NE    = 7;
    localparam int ST_TX_FULL  = 6;
    localparam int ST_RX_OVR   = 5;
    localparam int ST_TX_EMPTY = 4;
    localparam int ST_RX_FERR  = 3;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    function automatic logic [15:0] half_div(input logic [15:0] d);
        return d >> 1;
    endfunction

endpackage

// File: rtl/zxunouart_fifo_if.sv
// ZX-Uno register port as seen by the UART: index, strobes and write data.
// The host drives through master, the UART listens through slave.
interface zxunouart_fifo_if;

    logic [7:0] zxuno_addr;
    logic       zxuno_regrd;
    logic       zxuno_regwr;
    logic [7:0] din;

    modport master (
        output zxuno_addr,
        output zxuno_regrd,
        output zxuno_regwr,
        output din
    );

    modport slave (
        input zxuno_addr,
        input zxuno_regrd,
        input zxuno_regwr,
        input din
    );

endinterface

// File: rtl/zxunouart_fifo_uart_fifo.sv
// Power-of-two circular FIFO with combinational head and occupancy count.
// A push into a full FIFO is dropped unless a pop frees a slot that cycle.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign full    = count == (AW + 1)'(DEPTH);
    assign empty   = count == '0;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (AW + 1)'(1);
            end else if (do_pop && !do_push) begin
                count <= count - (AW + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/zxunouart_fifo.sv
// ZX-Uno 8N1 UART with RX/TX FIFOs behind the ZX-Uno register port.
// Define UART_BAUDREG_EN to expose the run-time divisor register UARTBAUD.
module zxunouart_fifo
    import zxunouart_fifo_pkg::*;
#(
    parameter int CLKFREQ  = 28000000,
    parameter int BAUDRATE = 115200,
    parameter int RXDEPTH  = 16,
    parameter int TXDEPTH  = 16
) (
    input  logic            clk,
    input  logic            rst,
    zxunouart_fifo_if.slave bus,
    output logic [7:0]      dout,
    output logic            oe_n,
    output logic            uart_tx,
    input  logic            uart_rx,
    output logic            uart_rts
);
    localparam int          BAUDDIV = CLKFREQ / BAUDRATE;
    localparam logic [15:0] DIV0    = 16'(BAUDDIV);
    localparam int          RAW     = $clog2(RXDEPTH);
    localparam int          TAW     = $clog2(TXDEPTH);

    logic          sel_data;
    logic          sel_stat;
    logic          rd_data;
    logic          rd_stat;
    logic          wr_data;
    logic          rd_data_q;
    logic          rd_stat_q;
    logic          wr_data_q;
    logic          rx_pop;
    logic          stat_clr;
    logic          tx_push;
    logic [15:0]   divisor;
    logic [7:0]    stat;
    logic [7:0]    rd_val;
    logic          rd_hit;

    logic [7:0]    rx_head;
    logic [RAW:0]  rx_count;
    logic [RAW:0]  rx_free;
    logic          rx_empty;
    logic          rx_full;
    logic [7:0]    tx_head;
    logic [TAW:0]  tx_count;
    logic          tx_empty;
    logic          tx_full;
    logic          rx_ovr;
    logic          rx_ferr;

    assign sel_data = bus.zxuno_addr == UARTDATA;
    assign sel_stat = bus.zxuno_addr == UARTSTAT;
    assign rd_data  = bus.zxuno_regrd & sel_data;
    assign rd_stat  = bus.zxuno_regrd & sel_stat;
    assign wr_data  = bus.zxuno_regwr & sel_data;

    // Strobes are levels: act once on the write rise and the read fall.
    assign rx_pop   = rd_data_q & ~rd_data;
    assign stat_clr = rd_stat_q & ~rd_stat;
    assign tx_push  = wr_data & ~wr_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= 1'b0;
            rd_stat_q <= 1'b0;
            wr_data_q <= 1'b0;
        end else begin
            rd_data_q <= rd_data;
            rd_stat_q <= rd_stat;
            wr_data_q <= wr_data;
        end
    end

`ifdef UART_BAUDREG_EN
    logic sel_baud;
    logic wr_baud;
    logic wr_baud_q;
    logic baud_hi;

    assign sel_baud = bus.zxuno_addr == UARTBAUD;
    assign wr_baud  = bus.zxuno_regwr & sel_baud;

    always_ff @(posedge clk) begin
        if (rst) begin
            divisor   <= DIV0;
            baud_hi   <= 1'b0;
            wr_baud_q <= 1'b0;
        end else begin
            wr_baud_q <= wr_baud;
            if (wr_baud && !wr_baud_q) begin
                if (baud_hi) begin
                    divisor[15:8] <= bus.din;
                end else begin
                    divisor[7:0] <= bus.din;
                end
                baud_hi <= ~baud_hi;
            end
        end
    end
`else
    assign divisor = DIV0;
`endif

    assign rx_empty = rx_count == '0;
    assign rx_full  = rx_count == (RAW + 1)'(RXDEPTH);
    assign tx_empty = tx_count == '0;
    assign tx_full  = tx_count == (TAW + 1)'(TXDEPTH);
    assign rx_free  = (RAW + 1)'(RXDEPTH) - rx_count;
    assign uart_rts = rx_free <= (RAW + 1)'(2);

    always_comb begin
        stat              = 8'h00;
        stat[ST_RX_NE]    = ~rx_empty;
        stat[ST_TX_FULL]  = tx_full;
        stat[ST_RX_OVR]   = rx_ovr;
        stat[ST_TX_EMPTY] = tx_empty;
        stat[ST_RX_FERR]  = rx_ferr;
    end

    always_comb begin
        rd_hit = 1'b0;
        rd_val = 8'h00;
        unique case (1'b1)
            sel_data: begin
                rd_hit = 1'b1;
                rd_val = rx_empty ? 8'h00 : rx_head;
            end
            sel_stat: begin
                rd_hit = 1'b1;
                rd_val = stat;
            end
`ifdef UART_BAUDREG_EN
            sel_baud: begin
                rd_hit = 1'b1;
                rd_val = baud_hi ? divisor[15:8] : divisor[7:0];
            end
`endif
            default: ;
        endcase
    end

    assign oe_n = ~(bus.zxuno_regrd & rd_hit);
    assign dout = oe_n ? 8'hzz : rd_val;

    // ---------------- transmitter ----------------
    tx_state_t   tx_st;
    tx_state_t   tx_st_n;
    logic [15:0] tx_cnt;
    logic [15:0] tx_div;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_sh;
    logic        tx_tick;
    logic        tx_pop;

    assign tx_tick = tx_cnt == tx_div - 16'd1;

    always_comb begin
        tx_st_n = tx_st;
        tx_pop  = 1'b0;
        unique case (tx_st)
            TX_IDLE: begin
                if (!tx_empty) begin
                    tx_st_n = TX_START;
                    tx_pop  = 1'b1;
                end
            end
            TX_START: begin
                if (tx_tick) tx_st_n = TX_DATA;
            end
            TX_DATA: begin
                if (tx_tick && tx_bit == 3'd7) tx_st_n = TX_STOP;
            end
            TX_STOP: begin
                if (tx_tick) begin
                    if (!tx_empty) begin
                        tx_st_n = TX_START;
                        tx_pop  = 1'b1;
                    end else begin
                        tx_st_n = TX_IDLE;
                    end
                end
            end
            default: tx_st_n = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_st   <= TX_IDLE;
            uart_tx <= 1'b1;
            tx_cnt  <= '0;
            tx_div  <= DIV0;
            tx_bit  <= '0;
            tx_sh   <= '0;
        end else begin
            tx_st <= tx_st_n;
            if (tx_pop) begin
                uart_tx <= 1'b0;
                tx_sh   <= tx_head;
                tx_div  <= divisor;
                tx_cnt  <= '0;
                tx_bit  <= '0;
            end else if (tx_st != TX_IDLE) begin
                if (tx_tick) begin
                    tx_cnt <= '0;
                    if (tx_st == TX_START) begin
                        uart_tx <= tx_sh[0];
                    end else if (tx_st == TX_DATA) begin
                        // Ones shift in from the top, so bit 7 is followed by the stop level.
                        uart_tx <= tx_sh[1];
                        tx_sh   <= {1'b1, tx_sh[7:1]};
                        tx_bit  <= tx_bit + 3'd1;
                    end
                end else begin
                    tx_cnt <= tx_cnt + 16'd1;
                end
            end
        end
    end

    // ---------------- receiver ----------------
    rx_state_t   rx_st;
    rx_state_t   rx_st_n;
    logic        rx_s1;
    logic        rx_s2;
    logic        rx_prev;
    logic [15:0] rx_cnt;
    logic [15:0] rx_div;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_sh;
    logic        rx_adv;
    logic        rx_done;
    logic        rx_push;
    logic        ovr_set;
    logic        ferr_set;

    assign rx_adv = (rx_st == RX_START)
                  ? (rx_cnt == half_div(rx_div) - 16'd1)
                  : (rx_cnt == rx_div - 16'd1);

    always_comb begin
        rx_st_n  = rx_st;
        rx_done  = 1'b0;
        ferr_set = 1'b0;
        unique case (rx_st)
            RX_IDLE: begin
                if (rx_prev && !rx_s2) rx_st_n = RX_START;
            end
            RX_START: begin
                if (rx_adv) rx_st_n = rx_s2 ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (rx_adv && rx_bit == 3'd7) rx_st_n = RX_STOP;
            end
            RX_STOP: begin
                if (rx_adv) begin
                    rx_st_n  = RX_IDLE;
                    rx_done  = rx_s2;
                    ferr_set = ~rx_s2;
                end
            end
            default: rx_st_n = RX_IDLE;
        endcase
    end

    assign rx_push = rx_done & ~rx_full;
    assign ovr_set = rx_done & rx_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
            rx_st   <= RX_IDLE;
            rx_cnt  <= '0;
            rx_div  <= DIV0;
            rx_bit  <= '0;
            rx_sh   <= '0;
            rx_ovr  <= 1'b0;
            rx_ferr <= 1'b0;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            rx_st   <= rx_st_n;
            if (rx_st == RX_IDLE) begin
                rx_cnt <= '0;
                rx_bit <= '0;
                rx_div <= divisor;
            end else if (rx_adv) begin
                rx_cnt <= '0;
                if (rx_st == RX_DATA) begin
                    rx_sh  <= {rx_s2, rx_sh[7:1]};
                    rx_bit <= rx_bit + 3'd1;
                end
            end else begin
                rx_cnt <= rx_cnt + 16'd1;
            end
            if (ovr_set) begin
                rx_ovr <= 1'b1;
            end else if (stat_clr) begin
                rx_ovr <= 1'b0;
            end
            if (ferr_set) begin
                rx_ferr <= 1'b1;
            end else if (stat_clr) begin
                rx_ferr <= 1'b0;
            end
        end
    end

    uart_fifo #(.WIDTH(8), .DEPTH(RXDEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (rx_pop),
        .wdata (rx_sh),
        .rdata (rx_head),
        .count (rx_count)
    );

    uart_fifo #(.WIDTH(8), .DEPTH(TXDEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (tx_pop),
        .wdata (bus.din),
        .rdata (tx_head),
        .count (tx_count)
    );

endmodule

// File: doc/zxunouart_fifo.md
ZXUNOUART_FIFO -- requirements
Module: zxunouart_fifo

Interface
REQ-001 SHALL have parameter CLKFREQ, default 28000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUDRATE, default 115200, power-up baud rate; reset divisor BAUDDIV = CLKFREQ/BAUDRATE, truncated.
REQ-003 SHALL have parameter RXDEPTH, default 16, RX FIFO entries; power of two, 4..256.
REQ-004 SHALL have parameter TXDEPTH, default 16, TX FIFO entries; power of two, 4..256.
REQ-005 SHALL have ports: clk in 1 system clock; rst in 1 reset, synchronous, active-high; zxuno_addr in 8 register index; zxuno_regrd in 1 read strobe, level; zxuno_regwr in 1 write strobe, level; din in 8 write data; dout out 8 read data; oe_n out 1 read enable, active-low; uart_tx out 1 serial out; uart_rx in 1 serial in, asynchronous; uart_rts out 1 flow control, active-low (0 = ready to receive).

Function
REQ-006 SHALL decode: UARTDATA reads RX FIFO head and writes TX FIFO; UARTSTAT is read-only.
REQ-007 SHALL drive dout/oe_n combinationally: oe_n=0 only while zxuno_regrd=1 on a decoded address; otherwise dout=8'hZZ, oe_n=1.
REQ-008 SHALL return UARTSTAT = {rx_not_empty, tx_full, rx_overrun, tx_empty, rx_frame_err, 3'b000}.
REQ-009 SHALL return RX head on a UARTDATA read, or 8'h00 when RX is empty; the pop SHALL occur once, in the cycle after zxuno_regrd falls, and SHALL be a no-op when empty.
REQ-010 SHALL push din into TX exactly once, on the first cycle zxuno_regwr=1 at UARTDATA; a push to a full TX SHALL be discarded.
REQ-011 SHALL execute a simultaneous push and pop on one FIFO in the same cycle, leaving the count unchanged; pointers SHALL wrap modulo depth.
REQ-012 SHALL transmit 8N1, LSB first, BAUDDIV clocks per bit, with uart_tx idle high; the TX engine SHALL pop the next byte in the start-bit cycle when TX is non-empty, giving back-to-back frames with no idle gap.
REQ-013 SHALL pass uart_rx through a 2-flop synchroniser; a falling edge in idle SHALL start a frame, and each bit SHALL be sampled at BAUDDIV/2 into its bit period.
REQ-014 SHALL abort the frame if the start bit samples high (glitch) and return to idle without flags.
REQ-015 SHALL discard the byte and set rx_frame_err if the stop bit samples low.
REQ-016 SHALL discard the byte and set rx_overrun when a valid byte arrives with RX full.
REQ-017 SHALL clear rx_overrun and rx_frame_err when a UARTSTAT read ends (zxuno_regrd falls); a set event in the same cycle SHALL win.
REQ-018 SHALL drive uart_rts=1 when RX free entries <= 2, and uart_rts=0 otherwise.
REQ-019 SHALL use RX states IDLE, START, DATA, STOP and TX states IDLE, START, DATA, STOP.

Reset
REQ-020 On rst SHALL: empty both FIFOs; clear all flags; put both engines in IDLE; drive uart_tx=1 and uart_rts=0; set divisor = BAUDDIV; clear pending read/write edge detectors.
REQ-021 Reset mid-frame SHALL abandon the frame immediately; uart_tx SHALL return high on the next clock.

Configuration
REQ-022 With UART_BAUDREG_EN defined, register UARTBAUD SHALL be read/write; writes SHALL alternately load divisor low/high byte (pointer starts low, resets on rst), and a new divisor SHALL take effect at the next frame start.
REQ-023 Without UART_BAUDREG_EN, the divisor SHALL be constant BAUDDIV, and UARTBAUD SHALL be undecoded (oe_n=1).

Structure
REQ-024 Register indices UARTDATA, UARTSTAT, UARTBAUD and the status bit positions SHALL come from the shared config package.
REQ-025 SHALL instantiate sub-module uart_fifo (parametrised width/depth, count output) twice; serialiser/deserialiser SHALL be local.

Verification
REQ-026 Write 8'h55 to UARTDATA, BAUDDIV=16 -> uart_tx start bit 1 cycle later, bits 1,0,1,0,1,0,1,0, stop; total 160 clocks.
REQ-027 Write 17 bytes with TXDEPTH=16 while the engine is stalled -> tx_full=1 after 16; 17th byte dropped; exactly 16 frames sent back-to-back.
REQ-028 Inject 8'hA3 on uart_rx -> UARTSTAT=8'h90 (bit7=1, bit4=1); UARTDATA read returns 8'hA3; after the read ends, UARTSTAT bit7=0.
REQ-029 Inject RXDEPTH+1 bytes without reading -> uart_rts=1 at RXDEPTH-2 entries; rx_overrun=1; first 16 bytes intact; flag clears after a UARTSTAT read.
REQ-030 Inject frame with stop bit 0, then a 0.25-bit low glitch -> rx_frame_err=1, nothing queued; glitch ignored.
REQ-031 Assert rst mid-TX frame -> uart_tx=1 next clock; UARTSTAT=8'h10.
